// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD operand driver.
// Optional latency tracking in gcd_driver is enabled by GCD_DRV_LATENCY_EN.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int unsigned DEFAULT_W    = 8;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/gcd_lfsr.sv
// 16-bit Galois LFSR with seed load and step enable.
// When load and en coincide, the register takes the step after the seed.
module gcd_lfsr
    import gcd_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else if (load) begin
            value <= en ? lfsr_step(SEED) : SEED;
        end else if (en) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/gcd_driver.sv
// Credit-limited operand initiator for the GCD ld/rdy interface with result accounting.
// Define GCD_DRV_LATENCY_EN to build the inter-result gap tracker behind maxgap.
module gcd_driver
    import gcd_pkg::*;
#(
    parameter int unsigned W      = DEFAULT_W,
    parameter int unsigned NOPS   = 100,
    parameter int unsigned MAXOUT = 2,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         ld,
    input  logic [W-1:0] q,
    input  logic         rdy,
    output logic         busy,
    output logic         done,
    output logic [15:0]  nres,
    output logic [15:0]  sum,
    output logic         err,
    output logic [15:0]  maxgap
);

    localparam int unsigned IW = $clog2(NOPS + 1);
    localparam int unsigned CW = $clog2(MAXOUT + 2);

    state_t        state, state_next;
    logic [IW-1:0] issued;
    logic [CW-1:0] cnt, cnt_next;
    logic [15:0]   lfsr, cur;
    logic [W-1:0]  field_a, field_b;
    logic          accept, has_out, counted, stray, ld_next;

    gcd_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (ld_next),
        .value (lfsr)
    );

    // The accepting edge issues straight from the seed, so the first ld follows start directly.
    always_comb begin
        accept   = (state == IDLE || state == DONE) && start;
        has_out  = (cnt != '0) || ld;
        counted  = rdy && has_out;
        stray    = rdy && !has_out;
        cnt_next = accept ? '0 : cnt + CW'(ld) - CW'(counted);
        ld_next  = accept ||
                   (state == RUN && issued < IW'(NOPS) && cnt_next < CW'(MAXOUT));
        cur      = accept ? SEED : lfsr;
        field_a  = cur[W-1:0];
        field_b  = cur[15:16-W];
        if (field_a == '0) field_a = W'(1);
        if (field_b == '0) field_b = W'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (issued == IW'(NOPS)) state_next = DRAIN;
            DRAIN:      if (nres == 16'(NOPS)) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            issued <= '0;
            cnt    <= '0;
            ld     <= 1'b0;
            a      <= '0;
            b      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            nres   <= '0;
            sum    <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ld    <= ld_next;
            busy  <= (state_next == RUN) || (state_next == DRAIN);
            done  <= (state_next == DONE);
            if (stray) err <= 1'b1;
            if (accept) begin
                issued <= IW'(ld_next);
            end else if (ld_next) begin
                issued <= issued + IW'(1);
            end
            if (ld_next) begin
                a <= field_a;
                b <= field_b;
            end
            if (accept) begin
                nres <= '0;
                sum  <= '0;
            end else if (counted) begin
                nres <= nres + 16'd1;
                sum  <= sum + 16'(q);
            end
        end
    end

`ifdef GCD_DRV_LATENCY_EN
    logic [15:0] gap, gap_inc;

    always_comb begin
        gap_inc = (gap == '1) ? gap : gap + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap    <= '0;
            maxgap <= '0;
        end else if (accept) begin
            gap    <= '0;
            maxgap <= '0;
        end else if (state == RUN || state == DRAIN) begin
            if (counted) begin
                gap <= '0;
                if (gap_inc > maxgap) maxgap <= gap_inc;
            end else begin
                gap <= gap_inc;
            end
        end
    end
`else
    assign maxgap = '0;
`endif

endmodule

// File: doc/gcd_driver.md
Name: gcd_driver

Overview:
Hardware initiator for the GCD unit's `ld`/`rdy` operand interface. It generates operand pairs from an LFSR, pulses `ld` with credit-based flow control (at most MAXOUT results outstanding), and collects results on `rdy`. It also accumulates a result count and checksum. It sits on the opposite end of the GCD core's port, for on-chip self-test and throughput runs.

Parameters:
W, 8, operand/result width (1..8)
NOPS, 100, operand pairs issued per run (>=1)
MAXOUT, 2, max loads outstanding without a result (>=1)
SEED, 16'hACE1, LFSR value loaded at start (nonzero)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  begin run (sampled in IDLE/DONE only)
a  out  W  operand A to GCD
b  out  W  operand B to GCD
ld  out  1  operand-valid pulse, one cycle per pair
q  in  W  GCD result
rdy  in  1  result valid, one cycle per result
busy  out  1  high in RUN/DRAIN
done  out  1  high in DONE
nres  out  16  results collected this run
sum  out  16  sum of collected q, mod 2^16
err  out  1  sticky: rdy seen with nothing outstanding
maxgap  out  16  max cycles between result events (see Optional Feature)

Behaviour:
- All outputs are registered. Reset drives every output to 0, LFSR to SEED, state to IDLE, and clears the outstanding count. Reset mid-run aborts the run with no residual state.
- States:
  - IDLE: start -> RUN.
  - RUN: after the final issue -> DRAIN.
  - DRAIN: nres==NOPS -> DONE.
  - DONE: start -> RUN.
  - start is ignored in RUN/DRAIN.
- On RUN entry: clear issued, nres, sum, outstanding, maxgap; LFSR <= SEED. err is not cleared; only reset clears it.
- Outstanding count (cnt), updated every edge: cnt <= cnt + ld - (rdy && cnt+ld>0). Simultaneous ld and rdy is net zero.
- Issue decision at each edge: ld_next = (state==RUN) && issued<NOPS && cnt_next<MAXOUT.
  - When ld_next=1: a <= field A of current LFSR, b <= field B, LFSR steps, issued++.
  - a/b hold their values when ld=0.
- First ld is high in the cycle after the edge that samples start. Back-to-back ld pulses are allowed until the credit limit is reached.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400.
  - Field A = lfsr[W-1:0]; field B = lfsr[15:16-W].
  - A zero field is replaced by 1, so the GCD core never sees a zero operand.
- Result: rdy with cnt+ld>0 -> nres++, sum <= sum+zero-extended q.
- rdy with cnt==0 and ld==0 (any state) -> err<=1; the result is ignored for nres and sum.
- done stays high until the next start is accepted; busy = RUN||DRAIN.

Optional Feature:
- Macro GCD_DRV_LATENCY_EN.
- When defined:
  - A 16-bit gap counter runs while busy, restarting at 0 on RUN entry and after each counted result.
  - On each counted result, maxgap <= max(maxgap, gap+1).
  - The counter saturates at 16'hFFFF.
- When undefined: maxgap is tied to 0, no counter is built, and the port remains present.

Decomposition:
- Shared package gcd_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - LFSR tap mask 16'hB400
  - default SEED
  - default W
- One natural sub-module: gcd_lfsr (16-bit Galois step with load and enable).
- FSM, credit counter and accumulators stay in gcd_driver.

Test Plan:
1. Reset 3 cycles, start pulse; bench responder returns q=1 five cycles after each ld.
   - First ld carries a=225 (8'hE1), b=172 (8'hAC).
   - After 100 results: done=1, nres=100, sum=100, err=0.
2. Responder silent after start: exactly 2 ld pulses ever.
   - busy=1, nres=0; no third ld for 50 cycles.
3. NOPS=4, responder q=3, two cycles after each ld:
   - exactly 4 ld pulses, then DRAIN, then DONE.
   - nres=4, sum=12; a subsequent start repeats a=225, b=172.
4. cnt=2 and rdy on the same edge that a new ld is sampled: cnt stays 2, no extra ld, nres+1.
5. rdy pulsed in IDLE with q=9: err=1, nres=0, sum=0; err survives a later start.
6. Reset asserted mid-run after 3 loads: all outputs 0 next cycle, state IDLE.
   - Restart reproduces a=225, b=172 first.
   - With GCD_DRV_LATENCY_EN and responder delay 7, maxgap=8 after the first result.
